// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller for the core's single interrupt input.
//
// Latches NSRC peripheral request lines as pending. Each source is either
// level or edge triggered. Pending sources are masked by ENABLE, and the
// result drives one registered interrupt line. Software services the
// interrupt through a claim/complete register pair on a Wishbone slave port.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous reset, active-high
//   i_src       interrupt request lines, synchronous to i_clk
//   i_wb_cyc    wishbone cycle
//   i_wb_stb    wishbone strobe
//   i_wb_we     1 = write
//   i_wb_adr    byte address; only bits [4:2] are decoded
//   i_wb_dat    write data
//   i_wb_sel    byte enables
//   o_wb_dat    read data, valid while o_wb_ack = 1
//   o_wb_ack    single-cycle acknowledge
//   o_irq       interrupt request to the core, registered
//
// Register map (word index = adr[4:2]):
//   0 PENDING  RO, write-1-to-clear (edge sources only)
//   1 ENABLE   RW, per-byte
//   2 CLAIM    read = claim, write = complete
//   3 TRIGGER  RW, per-byte, 1 = edge, 0 = level
//   4 STATUS   RO {busy[8], active_id[4:0]}
//   5-7        read 0, writes ignored
module irq_ctrl #(
  parameter int NSRC      = 8,
  parameter bit SRC_RESET = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NSRC-1:0] i_src,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [31:0]     i_wb_adr,
  input  logic [31:0]     i_wb_dat,
  input  logic [3:0]      i_wb_sel,
  output logic [31:0]     o_wb_dat,
  output logic            o_wb_ack,
  output logic            o_irq
);

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_ENABLE  = 3'd1;
  localparam logic [2:0] A_CLAIM   = 3'd2;
  localparam logic [2:0] A_TRIGGER = 3'd3;
  localparam logic [2:0] A_STATUS  = 3'd4;

  logic [NSRC-1:0] r_pending;
  logic [NSRC-1:0] r_enable;
  logic [NSRC-1:0] r_trigger;
  logic [NSRC-1:0] r_src_q;
  logic            r_busy;
  logic [4:0]      r_active_id;
  logic            r_ack;
  logic [31:0]     r_dat;
  logic            r_irq;

  logic            w_access;
  logic [2:0]      w_reg;
  logic            w_claim_rd;
  logic            w_claim;
  logic            w_complete;
  logic            w_w1c;
  logic            w_enable_wr;
  logic            w_trigger_wr;
  logic [NSRC-1:0] w_eligible;
  logic            w_claim_hit;
  logic [4:0]      w_claim_idx;
  logic [4:0]      w_claim_id;
  logic [31:0]     w_byte_mask;
  logic [NSRC-1:0] w_wmask;
  logic [NSRC-1:0] w_pending_next;
  logic [NSRC-1:0] w_enable_next;
  logic [NSRC-1:0] w_trigger_next;
  logic [31:0]     w_rdata;

  // The ack register blocks the cycle after an access, so a held strobe
  // is accepted every other cycle.
  assign w_access     = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_reg        = i_wb_adr[4:2];
  assign w_claim_rd   = w_access & ~i_wb_we & (w_reg == A_CLAIM);
  assign w_w1c        = w_access &  i_wb_we & (w_reg == A_PENDING);
  assign w_enable_wr  = w_access &  i_wb_we & (w_reg == A_ENABLE);
  assign w_trigger_wr = w_access &  i_wb_we & (w_reg == A_TRIGGER);
  assign w_eligible   = r_pending & r_enable;

  // Lowest-index eligible source wins the claim.
  always_comb begin
    w_claim_hit = 1'b0;
    w_claim_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_claim_hit = 1'b1;
        w_claim_idx = 5'(i);
      end
    end
  end

  assign w_claim_id = w_claim_idx + 5'd1;
  assign w_claim    = w_claim_rd & ~r_busy & w_claim_hit;
  assign w_complete = w_access & i_wb_we & (w_reg == A_CLAIM) & r_busy &
                      (i_wb_dat[4:0] == r_active_id);

  assign w_byte_mask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                        {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign w_wmask     = w_byte_mask[NSRC-1:0];

  assign w_enable_next  = w_enable_wr ?
                          ((r_enable & ~w_wmask) | (i_wb_dat[NSRC-1:0] & w_wmask)) :
                          r_enable;
  assign w_trigger_next = w_trigger_wr ?
                          ((r_trigger & ~w_wmask) | (i_wb_dat[NSRC-1:0] & w_wmask)) :
                          r_trigger;

  // Per-source pending update. For edge sources a new edge always wins over
  // a clear (W1C or claim) arriving on the same clock, so no event is lost.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic w_edge;
      logic w_clr;
      assign w_edge = i_src[gi] & ~r_src_q[gi];
      assign w_clr  = (w_w1c & i_wb_dat[gi]) |
                      (w_claim & (w_claim_idx == 5'(gi)));
      assign w_pending_next[gi] = r_trigger[gi] ?
                                  (w_edge | (r_pending[gi] & ~w_clr)) :
                                  i_src[gi];
    end
  endgenerate

  // Read mux; the claim value is computed from state before the claim.
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      A_PENDING: w_rdata = 32'(r_pending);
      A_ENABLE:  w_rdata = 32'(r_enable);
      A_CLAIM:   w_rdata = (~r_busy & w_claim_hit) ? {27'd0, w_claim_id} : 32'd0;
      A_TRIGGER: w_rdata = 32'(r_trigger);
      A_STATUS:  w_rdata = {23'd0, r_busy, 3'd0, r_active_id};
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending   <= '0;
      r_enable    <= '0;
      r_trigger   <= {NSRC{SRC_RESET}};
      r_src_q     <= '0;
      r_busy      <= 1'b0;
      r_active_id <= '0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_src_q   <= i_src;
      r_pending <= w_pending_next;
      r_enable  <= w_enable_next;
      r_trigger <= w_trigger_next;
      r_ack     <= w_access;
      r_dat     <= (w_access & ~i_wb_we) ? w_rdata : 32'd0;
      r_irq     <= ~r_busy & (|w_eligible);
      if (w_claim) begin
        r_busy      <= 1'b1;
        r_active_id <= w_claim_id;
      end else if (w_complete) begin
        r_busy      <= 1'b0;
        r_active_id <= '0;
      end
    end
  end

  assign o_wb_dat = r_dat;
  assign o_wb_ack = r_ack;
  assign o_irq    = r_irq;

  // Address bits outside [4:2] and high data/mask bits are intentionally ignored.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, i_wb_adr[31:5], i_wb_adr[1:0], i_wb_dat, w_byte_mask};

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  localparam int NSRC      = 8;
  localparam bit SRC_RESET = 1'b0;

  logic            clk = 1'b0;
  logic            rst;
  logic            cyc, stb, we;
  logic [31:0]     adr, wdat;
  logic [3:0]      sel;
  logic [NSRC-1:0] src;
  logic [31:0]     o_dat;
  logic            o_ack, o_irq;

  always #5 clk = ~clk;

  irq_ctrl #(.NSRC(NSRC), .SRC_RESET(SRC_RESET)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_src    (src),
    .i_wb_cyc (cyc),
    .i_wb_stb (stb),
    .i_wb_we  (we),
    .i_wb_adr (adr),
    .i_wb_dat (wdat),
    .i_wb_sel (sel),
    .o_wb_dat (o_dat),
    .o_wb_ack (o_ack),
    .o_irq    (o_irq)
  );

  typedef struct {
    bit          rd;
    logic [31:0] dat;
  } sb_t;
  sb_t sb_q[$];

  int checks = 0;
  int errors = 0;
  int n_acks = 0;

  // Behavioural reference state
  logic [NSRC-1:0] m_pend, m_en, m_trig, m_srcq;
  logic            m_busy, m_ack, m_irq;
  logic [4:0]      m_active;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_update();
    logic        acc;
    int          r;
    int          low;
    logic [NSRC-1:0] pn;
    logic [31:0] rv;
    logic        ev, clr;
    sb_t         e;
    if (rst) begin
      m_pend = '0; m_en = '0; m_trig = {NSRC{SRC_RESET}}; m_srcq = '0;
      m_busy = 1'b0; m_ack = 1'b0; m_irq = 1'b0; m_active = '0;
      return;
    end
    acc = cyc && stb && !m_ack;
    r   = int'(adr[4:2]);
    low = -1;
    for (int i = 0; i < NSRC; i++)
      if (m_pend[i] && m_en[i] && low < 0) low = i;
    case (r)
      0: rv = 32'(m_pend);
      1: rv = 32'(m_en);
      2: rv = (!m_busy && low >= 0) ? 32'(low + 1) : 32'd0;
      3: rv = 32'(m_trig);
      4: rv = (m_busy ? 32'h100 : 32'h0) + 32'(m_active);
      default: rv = 32'd0;
    endcase
    for (int i = 0; i < NSRC; i++) begin
      if (m_trig[i]) begin
        ev  = src[i] && !m_srcq[i];
        clr = (acc && we && r == 0 && wdat[i]) ||
              (acc && !we && r == 2 && !m_busy && low == i);
        pn[i] = ev || (m_pend[i] && !clr);
      end else begin
        pn[i] = src[i];
      end
    end
    m_irq = !m_busy && ((m_pend & m_en) != 0);
    if (acc) begin
      e.rd  = !we;
      e.dat = rv;
      sb_q.push_back(e);
      if (we && r == 1)
        for (int i = 0; i < NSRC; i++) if (sel[i/8]) m_en[i] = wdat[i];
      if (we && r == 3)
        for (int i = 0; i < NSRC; i++) if (sel[i/8]) m_trig[i] = wdat[i];
      if (!we && r == 2 && !m_busy && low >= 0) begin
        m_busy   = 1'b1;
        m_active = 5'(low + 1);
      end else if (we && r == 2 && m_busy && wdat[4:0] == m_active) begin
        m_busy   = 1'b0;
        m_active = '0;
      end
    end
    m_pend = pn;
    m_ack  = acc;
    m_srcq = src;
  endtask

  task automatic cycle();
    model_update();
    @(posedge clk);
    #1;
    chk("irq_cycle", 32'(o_irq), 32'(m_irq));
    chk("ack_cycle", 32'(o_ack), 32'(m_ack));
  endtask

  task automatic wb_rd(input int r, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = $urandom; adr[4:2] = 3'(r);
    cycle();
    d = o_dat;
    cyc = 1'b0; stb = 1'b0;
    cycle();
  endtask

  task automatic wb_wr(input int r, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = $urandom; adr[4:2] = 3'(r);
    wdat = d; sel = s;
    cycle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; src = '0;
    adr = '0; wdat = '0; sel = '0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  // Monitor: every ack pops the scoreboard; reads compare the returned data.
  always @(negedge clk) begin
    if (o_ack === 1'b1) begin
      sb_t e;
      n_acks++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with dat %h, expected no ack", o_dat);
      end else begin
        e = sb_q.pop_front();
        if (e.rd) begin
          $display("ack read  dat=%h expected=%h", o_dat, e.dat);
          chk("rd_data", o_dat, e.dat);
        end else begin
          $display("ack write");
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int base;

    // Reset state
    do_reset();
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_dat", o_dat, 32'd0);

    // 1: single edge pulse
    wb_wr(1, 32'h1, 4'hF);
    wb_wr(3, 32'h1, 4'hF);
    src = 8'h01; cycle();
    src = 8'h00;
    chk("t1_irq_t1", 32'(o_irq), 32'd0);
    cycle();
    chk("t1_irq_t2", 32'(o_irq), 32'd1);
    wb_rd(0, d); chk("t1_pending", d, 32'h01);

    // 2: claim ordering and complete
    do_reset();
    wb_wr(1, 32'hFF, 4'hF);
    wb_wr(3, 32'hFF, 4'hF);
    src = 8'h24; cycle();
    src = 8'h00; cycle(); cycle();
    wb_rd(2, d); chk("t2_claim1", d, 32'd3);
    chk("t2_irq_low", 32'(o_irq), 32'd0);
    wb_rd(4, d); chk("t2_status", d, 32'h103);
    wb_rd(2, d); chk("t2_claim_busy", d, 32'd0);
    wb_wr(2, 32'd3, 4'hF);
    chk("t2_irq_after_done", 32'(o_irq), 32'd1);
    wb_rd(2, d); chk("t2_claim2", d, 32'd6);

    // 3: level source, wrong then right complete
    do_reset();
    wb_wr(1, 32'h2, 4'hF);
    src = 8'h02; cycle(); cycle();
    wb_rd(2, d); chk("t3_claim", d, 32'd2);
    wb_wr(2, 32'd3, 4'hF);
    wb_rd(4, d); chk("t3_still_busy", d, 32'h102);
    chk("t3_irq_busy", 32'(o_irq), 32'd0);
    wb_wr(2, 32'd2, 4'hF);
    chk("t3_irq_reraise", 32'(o_irq), 32'd1);
    src = 8'h00;

    // 4: W1C versus a simultaneous new edge
    do_reset();
    wb_wr(3, 32'h1, 4'hF);
    src = 8'h01; cycle();
    src = 8'h00; cycle();
    wb_rd(0, d); chk("t4_pend_set", d, 32'h01);
    src = 8'h01;
    wb_wr(0, 32'h1, 4'hF);
    wb_rd(0, d); chk("t4_set_beats_w1c", d, 32'h01);
    wb_wr(0, 32'h1, 4'hF);
    wb_rd(0, d); chk("t4_w1c_clears", d, 32'h00);
    src = 8'h00;

    // 5: byte-enable write and held strobe
    do_reset();
    wb_wr(1, 32'hFFFF_FFFF, 4'b0001);
    wb_rd(1, d); chk("t5_enable_byte", d, 32'h0000_00FF);
    base = n_acks;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4;
    repeat (4) cycle();
    cyc = 1'b0; stb = 1'b0;
    cycle();
    chk("t5_ack_count", 32'(n_acks - base), 32'd2);

    // 6: reset over busy, irq and an in-flight ack
    do_reset();
    wb_wr(1, 32'h1, 4'hF);
    src = 8'h01; cycle(); cycle();
    chk("t6_irq_pre", 32'(o_irq), 32'd1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
    cycle();
    chk("t6_ack_pre", 32'(o_ack), 32'd1);
    chk("t6_irq_hold", 32'(o_irq), 32'd1);
    rst = 1'b1; src = 8'h00;
    cycle();
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    chk("t6_irq_rst", 32'(o_irq), 32'd0);
    chk("t6_ack_rst", 32'(o_ack), 32'd0);
    chk("t6_dat_rst", o_dat, 32'd0);
    cycle();
    wb_rd(3, d); chk("t6_trigger", d, 32'({NSRC{SRC_RESET}}));
    wb_rd(1, d); chk("t6_enable", d, 32'd0);
    wb_rd(0, d); chk("t6_pending", d, 32'd0);
    wb_rd(4, d); chk("t6_status", d, 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    wb_wr(3, $urandom, 4'hF);
    wb_wr(1, $urandom, 4'hF);
    for (int n = 0; n < 400; n++) begin
      int op;
      src = NSRC'($urandom);
      op  = $urandom_range(0, 7);
      case (op)
        0:       cycle();
        1:       wb_rd($urandom_range(0, 7), d);
        2:       wb_rd(2, d);
        3:       wb_wr(1, $urandom, 4'($urandom));
        4:       wb_wr(3, $urandom, 4'($urandom));
        5:       wb_wr(0, $urandom, 4'hF);
        6:       wb_wr(2, ($urandom_range(0, 3) != 0) ? {27'd0, m_active} : $urandom, 4'hF);
        default: wb_wr($urandom_range(4, 7), $urandom, 4'($urandom));
      endcase
    end
    src = '0;
    cycle(); cycle();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
